arc4_key_cracker: RTL and testbench
===================================

# arc4_key_cracker

Top-level brute-force ARC4 key search block for the board build. It holds a 256-byte ciphertext memory, runs two parallel ARC4 decrypt-and-check engines over the 24-bit key space, and reports the first key whose plaintext is entirely printable ASCII. The result goes to the six seven-segment displays; status goes to the LEDs.

## Interface
- Parameters: none.
- CLOCK_50  in  1  sole clock; all logic on rising edge.
- KEY  in  4  KEY[3] is reset: synchronous, active-high. KEY[2:0] unused.
- SW  in  10  unused.
- HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}. HEX5 is key[23:20], down to HEX0 is key[3:0].
- LEDR  out  10  LEDR[0]=done, LEDR[1]=found, LEDR[9:2]=0.
- Internal, hierarchically visible: `ct`, a 256x8 ciphertext memory with no logic write port, loaded externally. `key`, a 24-bit result register.

## Operation
- ct layout:
  - ct[0] = message length L, 1..255.
  - ct[1..L] = ciphertext bytes.
  - L=0 counts as an empty message; the first key tried (0x000000) succeeds.
- Key bytes for KSA: k[i mod 3], where k[0]=key[23:16], k[1]=key[15:8], k[2]=key[7:0].
- Each engine owns a private 256x8 S memory and iterates candidate keys. Per candidate it runs:
  - INIT: S[i]=i for i=0..255.
  - KSA: j=0; for i=0..255, j=(j+S[i]+k[i mod 3]) mod 256, then swap S[i],S[j].
  - PRGA/CHECK: i=j=0; for n=1..L:
    - i=i+1; j=j+S[i]; swap S[i],S[j].
    - p = S[(S[i]+S[j]) mod 256] XOR ct[n].
  - All index arithmetic is 8-bit wrap.
- Candidate rejection: stop PRGA on the first p outside 0x20..0x7E inclusive, then advance to the next candidate.
- Engine E0 tries even keys 0,2,4,… and engine E1 tries odd keys 1,3,5,…; each steps by 2.
- Arbitration: the first engine to finish CHECK with all L bytes valid wins. `key` is loaded with its candidate, found=1, done=1, and both engines halt. If both succeed in the same cycle, the lower key (E0) wins.
- Exhaustion: when every engine has passed 0xFFFFFF with no success, found=0 and done=1.
- States: IDLE → INIT → KSA → PRGA → NEXT (back to INIT) or SUCCESS or EXHAUSTED.
  - SUCCESS and EXHAUSTED are terminal until reset.
  - ct is read-shared; engines read ct through arbitration or a duplicated read port, implementer's choice, provided the timing bound holds.
- Display rules:
  - Searching (done=0): all HEX = 7'b1111111 (blank).
  - found=1: hex digit of each nibble of `key`, standard 0-F glyphs (b, d lowercase).
  - done=1, found=0: all HEX = 7'b0111111 (dash).

## Timing
- Reset (KEY[3]=1 on a clock edge):
  - `key`=0, done=0, found=0, HEX blank, LEDR=0.
  - Engines return to IDLE with candidate keys 0 and 1.
  - Search starts on the first cycle after reset deasserts.
- Reset mid-search or after completion aborts everything and restarts from key 0/1. ct contents are preserved.
- Per-candidate latency: at most 256 + 4·256 + 6·L + 4 cycles.
- S memory: single port, synchronous read with 1-cycle latency. One access per cycle per engine.
- done, found and the HEX outputs update in the cycle after the winning engine's final check.
- A successful key at index N is reported within (N/2+1)·max_per_candidate + 4 cycles of reset release.

## Configuration
- DOUBLE_CRACK_EN defined: two engines, even/odd split as above.
- DOUBLE_CRACK_EN undefined:
  - Only E0 is built; it steps by 1 through 0..0xFFFFFF.
  - No arbitration logic.
  - All other behaviour is identical.

## Test plan
- Reset, then load ct with L=0 → within 4 cycles of search start, key=0x000000, LEDR[1:0]=2'b11, HEX5..HEX0 show "000000".
- ct = "Hi" encrypted with key 0x000003 → key=0x000003 found by E1, done/found=1, HEX0 shows 3 and HEX1..HEX5 show 0, all within 30,000 cycles.
- Hold reset, reload ct with text encrypted under key 0x000002, release reset → key=0x000002, reported by E0 (the even engine), and the prior result is cleared at reset.
- Construct ct so that keys 0x000004 and 0x000005 both decrypt to printable text of equal length → key=0x000004 (tie goes to E0).
- Assert reset mid-search (after 500 cycles) → outputs blank and LEDR=0 next cycle, and the search restarts from key 0 and finds the same key again.
- ct with L=1 and ct[1] chosen so that no key yields a byte in 0x20..0x7E (use a forced-reject hook in the bench) → done=1, found=0, all HEX dashes.

Source files
------------

// File: rtl/arc4_key_cracker_if.sv
// rtl/arc4_key_cracker_if.sv - board-side switches, seven-segment displays and LEDs of the ARC4 key cracker
interface arc4_key_cracker_if;
    logic [9:0] SW;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic [9:0] LEDR;

    modport master (
        input  SW,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR
    );

    modport slave (
        output SW,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR
    );
endinterface

// File: rtl/arc4_key_cracker.sv
// rtl/arc4_key_cracker.sv - brute-force ARC4 24-bit key search with seven-segment result display (option macro: DOUBLE_CRACK_EN)
module arc4_key_cracker (
    input  logic                      CLOCK_50,
    input  logic [3:0]                KEY,
    arc4_key_cracker_if.master        board
);
`ifdef DOUBLE_CRACK_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif
    // Each engine advances its candidate by the number of engines so the key space is split evenly.
    localparam logic [24:0] STEP  = 25'(NE);
    localparam logic [6:0]  BLANK = 7'b1111111;
    localparam logic [6:0]  DASH  = 7'b0111111;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_KSA, ST_PRGA, ST_NEXT, ST_SUCCESS, ST_EXHAUSTED
    } state_t;

    logic clk;
    logic rst;
    assign clk = CLOCK_50;
    assign rst = KEY[3];

    logic unused_ok;
    assign unused_ok = ^{board.SW, KEY[2:0]};

    // Ciphertext image, loaded from outside the logic; ct[0] is the message length.
    logic [7:0]  ct [0:255];
    logic [23:0] key;
    logic        done_q;
    logic        found_q;

    logic [7:0]           len_w;
    logic [NE-1:0]        pass_w;
    logic [NE-1:0]        exh_w;
    logic [NE-1:0][23:0]  cand_w;

    assign len_w = ct[0];

    for (genvar e = 0; e < NE; e++) begin : g_eng
        state_t      st_q;
        logic [2:0]  ph_q;
        logic [23:0] cand_q;
        logic [7:0]  i_q;
        logic [7:0]  j_q;
        logic [7:0]  n_q;
        logic [7:0]  si_q;
        logic [7:0]  sj_q;
        logic [1:0]  km_q;
        logic [7:0]  s_mem [0:255];
        logic [7:0]  rdata_q;
        logic [7:0]  addr_w;
        logic [7:0]  wdata_w;
        logic        we_w;
        logic [7:0]  kbyte_w;
        logic [7:0]  jksa_w;
        logic [7:0]  p_w;
        logic        prn_w;
        logic [24:0] cand_nx_w;

        assign kbyte_w   = (km_q == 2'd0) ? cand_q[23:16] :
                           (km_q == 2'd1) ? cand_q[15:8]  : cand_q[7:0];
        assign jksa_w    = j_q + rdata_q + kbyte_w;
        assign p_w       = rdata_q ^ ct[n_q];
        assign prn_w     = (p_w >= 8'h20) && (p_w <= 8'h7E);
        assign cand_nx_w = {1'b0, cand_q} + STEP;

        // An empty message accepts the very first candidate straight out of IDLE.
        assign pass_w[e] = !done_q &&
                           (((st_q == ST_IDLE) && (len_w == 8'd0)) ||
                            ((st_q == ST_PRGA) && (ph_q == 3'd5) && prn_w && (n_q == len_w)));
        assign exh_w[e]  = (st_q == ST_EXHAUSTED);
        assign cand_w[e] = cand_q;

        // S port request for the current step: exactly one read or one write per cycle
        always_comb begin
            addr_w  = 8'd0;
            wdata_w = 8'd0;
            we_w    = 1'b0;
            case (st_q)
                ST_INIT: begin
                    addr_w  = i_q;
                    wdata_w = i_q;
                    we_w    = !done_q;
                end
                ST_KSA: begin
                    case (ph_q)
                        3'd0: addr_w = i_q;
                        3'd1: addr_w = jksa_w;
                        3'd2: begin addr_w = i_q; wdata_w = rdata_q; we_w = !done_q; end
                        3'd3: begin addr_w = j_q; wdata_w = si_q;    we_w = !done_q; end
                        default: ;
                    endcase
                end
                ST_PRGA: begin
                    case (ph_q)
                        3'd0: addr_w = i_q + 8'd1;
                        3'd1: addr_w = j_q + rdata_q;
                        3'd2: begin addr_w = i_q; wdata_w = rdata_q; we_w = !done_q; end
                        3'd3: begin addr_w = j_q; wdata_w = si_q;    we_w = !done_q; end
                        3'd4: addr_w = si_q + sj_q;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        // Private single-port S memory with one cycle of read latency
        always_ff @(posedge clk) begin
            if (we_w) begin
                s_mem[addr_w] <= wdata_w;
            end
            rdata_q <= s_mem[addr_w];
        end

        // Candidate walk: INIT, KSA, PRGA/check, then next key; frozen once a result is latched
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= ST_IDLE;
                ph_q   <= 3'd0;
                cand_q <= 24'(e);
                i_q    <= 8'd0;
                j_q    <= 8'd0;
                n_q    <= 8'd0;
                si_q   <= 8'd0;
                sj_q   <= 8'd0;
                km_q   <= 2'd0;
            end else if (!done_q) begin
                case (st_q)
                    ST_IDLE: begin
                        i_q  <= 8'd0;
                        st_q <= (len_w == 8'd0) ? ST_SUCCESS : ST_INIT;
                    end
                    ST_INIT: begin
                        i_q <= i_q + 8'd1;
                        if (i_q == 8'hFF) begin
                            st_q <= ST_KSA;
                            ph_q <= 3'd0;
                            j_q  <= 8'd0;
                            km_q <= 2'd0;
                        end
                    end
                    ST_KSA: begin
                        case (ph_q)
                            3'd0: ph_q <= 3'd1;
                            3'd1: begin si_q <= rdata_q; j_q <= jksa_w; ph_q <= 3'd2; end
                            3'd2: ph_q <= 3'd3;
                            default: begin
                                ph_q <= 3'd0;
                                i_q  <= i_q + 8'd1;
                                km_q <= (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
                                if (i_q == 8'hFF) begin
                                    st_q <= ST_PRGA;
                                    j_q  <= 8'd0;
                                    n_q  <= 8'd1;
                                end
                            end
                        endcase
                    end
                    ST_PRGA: begin
                        case (ph_q)
                            3'd0: begin i_q <= i_q + 8'd1; ph_q <= 3'd1; end
                            3'd1: begin si_q <= rdata_q; j_q <= j_q + rdata_q; ph_q <= 3'd2; end
                            3'd2: begin sj_q <= rdata_q; ph_q <= 3'd3; end
                            3'd3: ph_q <= 3'd4;
                            3'd4: ph_q <= 3'd5;
                            default: begin
                                ph_q <= 3'd0;
                                if (!prn_w) begin
                                    st_q <= ST_NEXT;
                                end else if (n_q == len_w) begin
                                    st_q <= ST_SUCCESS;
                                end else begin
                                    n_q <= n_q + 8'd1;
                                end
                            end
                        endcase
                    end
                    ST_NEXT: begin
                        i_q <= 8'd0;
                        if (cand_nx_w[24]) begin
                            st_q <= ST_EXHAUSTED;
                        end else begin
                            cand_q <= cand_nx_w[23:0];
                            st_q   <= ST_INIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic        win_w;
    logic [23:0] win_key_w;

    // Pick the reporting engine; on a same-cycle tie the even engine holds the lower key
    always_comb begin
`ifdef DOUBLE_CRACK_EN
        win_w     = |pass_w;
        win_key_w = pass_w[0] ? cand_w[0] : cand_w[1];
`else
        win_w     = pass_w[0];
        win_key_w = cand_w[0];
`endif
    end

    // Latch the first winner, or report exhaustion once every engine has run off the key space
    always_ff @(posedge clk) begin
        if (rst) begin
            key     <= 24'd0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
        end else if (!done_q) begin
            if (win_w) begin
                key     <= win_key_w;
                done_q  <= 1'b1;
                found_q <= 1'b1;
            end else if (&exh_w) begin
                done_q  <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Displays: blank while searching, key digits when found, dashes when the space is exhausted
    always_comb begin
        board.HEX0 = BLANK;
        board.HEX1 = BLANK;
        board.HEX2 = BLANK;
        board.HEX3 = BLANK;
        board.HEX4 = BLANK;
        board.HEX5 = BLANK;
        if (done_q && found_q) begin
            board.HEX0 = seg7(key[3:0]);
            board.HEX1 = seg7(key[7:4]);
            board.HEX2 = seg7(key[11:8]);
            board.HEX3 = seg7(key[15:12]);
            board.HEX4 = seg7(key[19:16]);
            board.HEX5 = seg7(key[23:20]);
        end else if (done_q) begin
            board.HEX0 = DASH;
            board.HEX1 = DASH;
            board.HEX2 = DASH;
            board.HEX3 = DASH;
            board.HEX4 = DASH;
            board.HEX5 = DASH;
        end
    end

    assign board.LEDR = {8'd0, found_q, done_q};
endmodule

// File: tb/tb_arc4_key_cracker.sv
// tb/tb_arc4_key_cracker.sv - self-checking bench for arc4_key_cracker
module tb_arc4_key_cracker;
`ifdef DOUBLE_CRACK_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY;

    arc4_key_cracker_if board ();
    arc4_key_cracker dut (.CLOCK_50(CLOCK_50), .KEY(KEY), .board(board));

    always #10 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;
    logic [7:0] ct_img [256];
    logic [7:0] pt [256];

    typedef struct {
        string       name;
        logic [23:0] enc_key;
        int          len;
        logic [7:0]  ptb [16];
        logic [23:0] exp_key;
        int          bound;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit printable(input logic [7:0] p);
        return (int'(p) >= 32) && (int'(p) <= 126);
    endfunction

    // ARC4 keystream byte n (1-based) for a 24-bit key, written straight from the cipher definition
    function automatic logic [7:0] ks_byte(input logic [23:0] k, input int n);
        int s [256];
        int kb [3];
        int i, j, t;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + kb[a % 3]) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0; t = 0;
        for (int m = 1; m <= n; m++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[(s[i] + s[j]) % 256];
        end
        return 8'(t);
    endfunction

    function automatic bit model_ok(input logic [23:0] k);
        int len;
        len = int'(ct_img[0]);
        for (int n = 1; n <= len; n++)
            if (!printable(ks_byte(k, n) ^ ct_img[n])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] model_first();
        for (int k = 0; k < 4096; k++)
            if (model_ok(24'(k))) return 24'(k);
        return 24'hFFFFFF;
    endfunction

    function automatic int bound_for(input logic [23:0] k, input int len);
        int per;
        per = 256 + 4 * 256 + 6 * len + 4;
        return (int'(k) / NE + 1) * per + 4;
    endfunction

    function automatic logic [41:0] hex_all();
        return {board.HEX5, board.HEX4, board.HEX3, board.HEX2, board.HEX1, board.HEX0};
    endfunction

    function automatic logic [41:0] exp_hex(input logic [23:0] k, input bit found);
        logic [41:0] r;
        for (int d = 0; d < 6; d++) r[d*7 +: 7] = found ? GLYPH[k[d*4 +: 4]] : DASH;
        return r;
    endfunction

    task automatic build_ct(input logic [23:0] k, input int len);
        for (int a = 0; a < 256; a++) ct_img[a] = 8'h00;
        ct_img[0] = 8'(len);
        for (int n = 1; n <= len; n++) ct_img[n] = ks_byte(k, n) ^ pt[n];
    endtask

    task automatic hold_reset_and_load();
        @(negedge CLOCK_50);
        KEY[3] = 1'b1;
        @(negedge CLOCK_50);
        for (int a = 0; a < 256; a++) dut.ct[a] = ct_img[a];
        @(negedge CLOCK_50);
    endtask

    task automatic check_cleared(input string name);
        check({name, "/ledr"}, 64'(board.LEDR), 64'd0);
        check({name, "/hex"},  64'(hex_all()),  64'({6{BLANK}}));
        check({name, "/key"},  64'(dut.key),    64'd0);
    endtask

    // Called at a negedge with reset held; releases reset and waits a bounded time for done
    task automatic release_and_wait(input string name, input logic [23:0] exp_key, input bit exp_found,
                                    input int bound, input bit hook);
        int cyc;
        cyc = 0;
        KEY[3] = 1'b0;
        if (hook) begin
`ifdef DOUBLE_CRACK_EN
            dut.g_eng[0].cand_q = 24'hFFFFFE;
            dut.g_eng[1].cand_q = 24'hFFFFFF;
`else
            dut.g_eng[0].cand_q = 24'hFFFFFF;
`endif
        end
        while (board.LEDR[0] !== 1'b1 && cyc < bound) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        checks++;
        if (board.LEDR[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s/latency: done not seen after %0d cycles, limit %0d", name, cyc, bound);
        end
        check({name, "/ledr"}, 64'(board.LEDR), 64'({8'd0, exp_found, 1'b1}));
        if (exp_found) check({name, "/key"}, 64'(dut.key), 64'(exp_key));
        check({name, "/hex"}, 64'(hex_all()), 64'(exp_hex(exp_key, exp_found)));
    endtask

    task automatic set_msg(input int v, input string m);
        vecs[v].len = m.len();
        for (int n = 0; n < 16; n++) vecs[v].ptb[n] = 8'h00;
        for (int n = 0; n < m.len(); n++) vecs[v].ptb[n] = m[n];
    endtask

    task automatic load_pt(input int v);
        for (int a = 0; a < 256; a++) pt[a] = 8'h00;
        for (int n = 0; n < vecs[v].len; n++) pt[n + 1] = vecs[v].ptb[n];
    endtask

    initial begin
        logic [7:0]  c;
        logic [23:0] exp;
        bit          got;

        KEY = 4'b1000;
        board.SW = 10'd0;

        // Vector table: encryption key and plaintext in, expected key and latency bound from the model
        vecs[0].name = "empty"; vecs[0].enc_key = 24'd0; set_msg(0, "");
        vecs[1].name = "hi_k3"; vecs[1].enc_key = 24'd3; set_msg(1, "Hi");
        vecs[2].name = "txt_k2"; vecs[2].enc_key = 24'd2; set_msg(2, "Hello");
        for (int v = 3; v < 5; v++) begin
            vecs[v].name    = (v == 3) ? "rand0" : "rand1";
            vecs[v].enc_key = 24'($urandom_range(0, 7));
            vecs[v].len     = int'($urandom_range(3, 8));
            for (int n = 0; n < 16; n++) vecs[v].ptb[n] = 8'($urandom_range(32, 126));
        end
        for (int v = 0; v < 5; v++) begin
            load_pt(v);
            build_ct(vecs[v].enc_key, vecs[v].len);
            vecs[v].exp_key = model_first();
            vecs[v].bound   = (vecs[v].len == 0) ? 4 : bound_for(vecs[v].exp_key, vecs[v].len);
        end

        repeat (3) @(negedge CLOCK_50);
        check_cleared("reset");

        for (int v = 0; v < 5; v++) begin
            load_pt(v);
            build_ct(vecs[v].enc_key, vecs[v].len);
            hold_reset_and_load();
            check_cleared({vecs[v].name, "/cleared"});
            release_and_wait(vecs[v].name, vecs[v].exp_key, 1'b1, vecs[v].bound, 1'b0);
        end

        // Tie: every byte decrypts to printable text under both key 4 and key 5
        for (int a = 0; a < 256; a++) ct_img[a] = 8'h00;
        ct_img[0] = 8'd3;
        for (int n = 1; n <= 3; n++) begin
            got = 1'b0;
            for (int p = 32; p <= 126 && !got; p++) begin
                c = ks_byte(24'd4, n) ^ 8'(p);
                if (printable(ks_byte(24'd5, n) ^ c)) begin
                    ct_img[n] = c;
                    got = 1'b1;
                end
            end
        end
        exp = model_first();
        hold_reset_and_load();
        release_and_wait("tie", exp, 1'b1, bound_for(exp, 3), 1'b0);

        // Reset 500 cycles into a search, then expect the same answer from a fresh start
        load_pt(2);
        build_ct(vecs[2].enc_key, vecs[2].len);
        hold_reset_and_load();
        KEY[3] = 1'b0;
        repeat (500) @(negedge CLOCK_50);
        KEY[3] = 1'b1;
        @(negedge CLOCK_50);
        check_cleared("midrst");
        release_and_wait("midrst", vecs[2].exp_key, 1'b1, vecs[2].bound, 1'b0);

        // Exhaustion: engines jump to the top of the key space, where every remaining key rejects
        for (int a = 0; a < 256; a++) ct_img[a] = 8'h00;
        ct_img[0] = 8'd1;
        got = 1'b0;
        for (int v = 0; v < 256 && !got; v++) begin
            c = 8'(v);
            if (!printable(ks_byte(24'hFFFFFF, 1) ^ c) &&
                (NE == 1 || !printable(ks_byte(24'hFFFFFE, 1) ^ c))) begin
                ct_img[1] = c;
                got = 1'b1;
            end
        end
        hold_reset_and_load();
        release_and_wait("exhaust", 24'd0, 1'b0, 2 * bound_for(24'd0, 1), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
